// File: rtl/split_reg_arbiter.sv
// Two-requester round-robin arbiter that commits nibble-masked writes to a shared
// 8-bit register. Define SPLIT_REG_ARB_STATS_EN to build the commit counter x.
module split_reg_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [7:0]       req_data0,
  input  logic [1:0]       req_mask0,
  input  logic [7:0]       req_data1,
  input  logic [1:0]       req_mask1,
  output logic [1:0]       req_ready,
  output logic [3:0]       p1,
  output logic [3:0]       p2,
  output logic [CNT_W-1:0] x,
  output logic             busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_reg;
  logic       r_prio;
  logic       r_win;
  logic [7:0] r_lat_data;
  logic [1:0] r_lat_mask;

  logic       w_win;
  logic [7:0] w_sel_data;
  logic [1:0] w_sel_mask;

  // A lone requester wins outright; prio only breaks a tie.
  always_comb begin
    w_win      = (req_valid == 2'b11) ? r_prio : req_valid[1];
    w_sel_data = w_win ? req_data1 : req_data0;
    w_sel_mask = w_win ? req_mask1 : req_mask0;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; every register is reset here, there are no memories.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_reg      <= 8'h00;
      r_prio     <= 1'b0;
      r_win      <= 1'b0;
      r_lat_data <= 8'h00;
      r_lat_mask <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid != 2'b00) begin
            r_win      <= w_win;
            r_lat_data <= w_sel_data;
            r_lat_mask <= w_sel_mask;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (r_lat_mask[0]) r_reg[3:0] <= r_lat_data[3:0];
          if (r_lat_mask[1]) r_reg[7:4] <= r_lat_data[7:4];
          r_prio  <= ~r_win;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPLIT_REG_ARB_STATS_EN
  logic [CNT_W-1:0] r_x;
  logic             w_commit;

  // Empty-mask grants complete the handshake but are not counted.
  assign w_commit = (r_state == S_GRANT) && (r_lat_mask != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_x <= '0;
    else if (w_commit) r_x <= r_x + CNT_W'(1);
  end

  assign x = r_x;
`else
  assign x = '0;
`endif

  // Ready is decoded from state so an asynchronous reset drops it at once.
  assign req_ready = (r_state == S_GRANT) ? (r_win ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (r_state == S_GRANT);
  assign p1        = r_reg[3:0];
  assign p2        = r_reg[7:4];

endmodule
